mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data port; responds to the load/store address, write-enable and write-data signals the controller drives.
- Serialises queued bytes as 8N1 frames on a single `tx` line.
- Asserts `sel` when the data address falls in its window, so top-level logic steers `rd` into the core's load path instead of RAM read data.
- Single clock domain with the core.

---
 rtl/mmio_uart_tx_pkg.sv | 24 ++
 rtl/mmio_uart_tx_fifo.sv | 54 +++++
 rtl/mmio_uart_tx.sv | 207 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and the shifter state encoding.
package mmio_uart_tx_pkg;

  // Word offsets inside the 16-byte register window (addr[3:0], low bits zero)
  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;

  // STATUS register bit positions
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_BUSY_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_OVF_BIT   = 3;

  // Serial shifter states: one frame walks START -> DATA -> STOP
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous circular FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
// Read data is combinational from the head entry so the consumer can take
// the byte in the same cycle it pops. A push while full is accepted only
// when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update, wrapping naturally modulo 2*DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue bytes in a
// small FIFO; a shifter drains it one frame at a time, holding each bit
// for the divisor latched when the frame's byte was popped.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_INIT   = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  // Bus decode
  logic        w_sel;
  logic        w_wr;
  logic [3:0]  w_offset;
  logic        w_push;
  logic        w_unused;

  // FIFO interface
  logic        w_pop;
  logic [7:0]  w_fifo_dout;
  logic        w_full;
  logic        w_empty;

  // Control registers
  logic [15:0] r_div;
  logic        r_ovf;

  // Shifter state
  uart_tx_state_e r_state;
  uart_tx_state_e w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic [2:0]  w_idx_inc;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic [15:0] r_bit_div;
  logic [15:0] w_bit_div_next;
  logic        r_tx;
  logic        w_tx_next;
  logic        w_bit_end;
  logic        w_busy;

  assign w_sel    = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr     = w_sel && we;
  assign w_offset = {addr[3:2], 2'b00};
  assign w_push   = w_wr && (w_offset == UART_TXDATA);
  assign w_unused = ^{addr[1:0], wd[31:16]};

  assign w_bit_end = (r_cnt == 16'd0);
  assign w_idx_inc = r_idx + 3'd1;
  assign w_busy    = (r_state != IDLE) || !w_empty;

  assign sel  = w_sel;
  assign tx   = r_tx;
  assign busy = w_busy;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wd[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Divisor and sticky overflow flag, written through the register window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= DIV_INIT;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && (w_offset == UART_DIV)) begin
        r_div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
      end
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_offset == UART_STATUS) && wd[STATUS_OVF_BIT]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Combinational load data; zero outside the window and for write-only slots
  always_comb begin
    rd = 32'd0;
    if (w_sel) begin
      case (w_offset)
        UART_STATUS: begin
          rd[STATUS_FULL_BIT]  = w_full;
          rd[STATUS_BUSY_BIT]  = w_busy;
          rd[STATUS_EMPTY_BIT] = w_empty;
          rd[STATUS_OVF_BIT]   = r_ovf;
        end
        UART_DIV: rd = {16'd0, r_div};
        default:  rd = 32'd0;
      endcase
    end
  end

  // Shifter next state: pops a byte when free, then times each bit with a down-counter
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
    w_bit_div_next = r_bit_div;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_fifo_dout;
          w_bit_div_next = r_div;
          w_cnt_next     = r_div - 16'd1;
          w_tx_next      = 1'b0;
          w_state_next   = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_idx_next   = 3'd0;
          w_tx_next    = r_shift[0];
          w_cnt_next   = r_bit_div - 16'd1;
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_next = r_bit_div - 16'd1;
          if (r_idx == 3'd7) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_idx_next = w_idx_inc;
            w_tx_next  = r_shift[w_idx_inc];
          end
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            // Back-to-back frame: straight into the next start bit
            w_pop          = 1'b1;
            w_shift_next   = w_fifo_dout;
            w_bit_div_next = r_div;
            w_cnt_next     = r_div - 16'd1;
            w_tx_next      = 1'b0;
            w_state_next   = START;
          end else begin
            w_tx_next    = 1'b1;
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  // Shifter registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 16'd0;
      r_idx     <= 3'd0;
      r_shift   <= 8'd0;
      r_bit_div <= DIV_INIT;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_shift   <= w_shift_next;
      r_bit_div <= w_bit_div_next;
      r_tx      <= w_tx_next;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. A line monitor decodes every frame
// cycle by cycle and compares it with a scoreboard of expected bytes and
// divisors pushed when the bytes are written.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        tx;
  logic        busy;

  int   checks;
  int   failures;
  int   cyc;
  exp_t exp_q[$];
  int   start_cycles[$];

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4),
    .DIV_INIT   (16'd868)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .rd   (rd),
    .sel  (sel),
    .tx   (tx),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at posedge+2: drive a store, let the next edge take it, return at posedge+2
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #2;
    we   = 1'b0;
    addr = 32'h0;
    wd   = 32'h0;
  endtask

  // Combinational load, no clock edge consumed
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
    addr = a;
    #1;
    d = rd;
    s = sel;
  endtask

  // Wait until scoreboard and DUT are both drained, then realign to posedge+2
  task automatic wait_drain(input int bound, output bit ok);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = (n < bound);
    @(posedge clk);
    #2;
  endtask

  // Line monitor: every cycle of a frame is compared with its expected level
  task automatic run_monitor();
    exp_t       e;
    logic [7:0] got;
    logic       lvl;
    bit         bad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        start_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, required idle line", cyc);
          for (int k = 0; k < 20000 && tx === 1'b0; k++) @(negedge clk);
        end else begin
          e       = exp_q[0];
          bad     = 1'b0;
          aborted = 1'b0;
          got     = 8'h00;
          for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < e.div; c++) begin
              if (!aborted) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (rst !== 1'b0) begin
                  aborted = 1'b1;
                end else begin
                  if (b == 0)      lvl = 1'b0;
                  else if (b == 9) lvl = 1'b1;
                  else             lvl = e.data[b-1];
                  if (tx !== lvl) bad = 1'b1;
                  if (b >= 1 && b <= 8 && c == e.div / 2) got[b-1] = tx;
                end
              end
            end
          end
          if (aborted) begin
            $display("frame data=%02h aborted by reset", e.data);
          end else begin
            void'(exp_q.pop_front());
            checks++;
            if (got !== e.data) begin
              failures++;
              $display("FAIL frame_data: got %02h required %02h", got, e.data);
            end
            checks++;
            if (bad) begin
              failures++;
              $display("FAIL frame_timing: data=%02h line deviated from %0d cycles/bit 8N1 shape", e.data, e.div);
            end
            $display("frame data=%02h div=%0d start_cycle=%0d", got, e.div, start_cycles[start_cycles.size()-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        s;
    rst  = 1'b1;
    we   = 1'b0;
    addr = 32'h0;
    wd   = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    bus_read(BASE + 32'h4, d, s);
    checks++;
    if (d !== 32'h4 || s !== 1'b1) begin failures++; $display("FAIL reset_status: got %08h sel=%b required 00000004 sel=1", d, s); end
    bus_read(BASE + 32'h8, d, s);
    checks++;
    if (d !== 32'd868) begin failures++; $display("FAIL reset_div: got %0d required 868", d); end
    bus_read(BASE + 32'h0, d, s);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL txdata_read: got %08h required 0", d); end
    bus_read(BASE + 32'hC, d, s);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reserved_read: got %08h required 0", d); end
  endtask

  task automatic test_single_frame();
    int cyc_n;
    int k0;
    int n;
    bus_write(BASE + 32'h8, 32'd4);
    k0 = start_cycles.size();
    exp_q.push_back('{8'hA5, 4});
    bus_write(BASE + 32'h0, 32'hA5);
    cyc_n = cyc;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc !== cyc_n + 41) begin failures++; $display("FAIL busy_fall: busy low at cycle %0d required %0d", cyc, cyc_n + 41); end
    checks++;
    if (start_cycles.size() != k0 + 1) begin
      failures++;
      $display("FAIL single_frame_count: got %0d frames required 1", start_cycles.size() - k0);
    end else if (start_cycles[k0] != cyc_n + 1) begin
      failures++;
      $display("FAIL start_latency: start at cycle %0d required %0d", start_cycles[k0], cyc_n + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL single_frame_drain: %0d frames outstanding required 0", exp_q.size()); end
    @(posedge clk);
    #2;
  endtask

  task automatic test_back_to_back();
    int          cyc_n;
    int          k0;
    bit          ok;
    bit          gap_bad;
    logic [31:0] d;
    logic        s;
    bus_write(BASE + 32'h8, 32'd2);
    k0 = start_cycles.size();
    cyc_n = 0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back('{i[7:0], 2});
      bus_write(BASE + 32'h0, i);
      if (i == 1) cyc_n = cyc;
    end
    bus_read(BASE + 32'h4, d, s);
    checks++;
    if (d[3] !== 1'b0) begin failures++; $display("FAIL b2b_overflow: got %b required 0", d[3]); end
    wait_drain(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_timeout: %0d frames outstanding required 0", exp_q.size()); end
    checks++;
    if (start_cycles.size() != k0 + 5) begin
      failures++;
      $display("FAIL b2b_count: got %0d frames required 5", start_cycles.size() - k0);
    end else begin
      gap_bad = (start_cycles[k0] != cyc_n + 1);
      for (int i = 1; i < 5; i++)
        if (start_cycles[k0+i] - start_cycles[k0+i-1] != 20) gap_bad = 1'b1;
      if (gap_bad) begin
        failures++;
        $display("FAIL b2b_contiguous: starts %0d %0d %0d %0d %0d required %0d plus multiples of 20",
                 start_cycles[k0], start_cycles[k0+1], start_cycles[k0+2], start_cycles[k0+3], start_cycles[k0+4], cyc_n + 1);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic        s;
    bit          ok;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back('{8'h11 * (i + 1), 2});
      bus_write(BASE + 32'h0, 8'h11 * (i + 1));
    end
    bus_read(BASE + 32'h4, d, s);
    checks++;
    if (d !== 32'h0B) begin failures++; $display("FAIL status_overflow: got %08h required 0000000b", d); end
    bus_write(BASE + 32'h4, 32'h7);
    bus_read(BASE + 32'h4, d, s);
    checks++;
    if (d !== 32'h0B) begin failures++; $display("FAIL overflow_kept: got %08h required 0000000b", d); end
    bus_write(BASE + 32'h4, 32'h8);
    bus_read(BASE + 32'h4, d, s);
    checks++;
    if (d !== 32'h03) begin failures++; $display("FAIL overflow_clear: got %08h required 00000003", d); end
    wait_drain(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL overflow_timeout: %0d frames outstanding required 0", exp_q.size()); end
    bus_read(BASE + 32'h4, d, s);
    checks++;
    if (d !== 32'h04) begin failures++; $display("FAIL overflow_after_drain: got %08h required 00000004", d); end
  endtask

  task automatic test_div_change();
    logic [31:0] d;
    logic        s;
    bit          ok;
    int          k0;
    bus_write(BASE + 32'h8, 32'd4);
    k0 = start_cycles.size();
    exp_q.push_back('{8'h55, 4});
    bus_write(BASE + 32'h0, 32'h55);
    exp_q.push_back('{8'h0F, 8});
    bus_write(BASE + 32'h0, 32'h0F);
    bus_write(BASE + 32'h8, 32'd8);
    wait_drain(500, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL div_change_timeout: %0d frames outstanding required 0", exp_q.size()); end
    checks++;
    if (start_cycles.size() != k0 + 2) begin
      failures++;
      $display("FAIL div_change_count: got %0d frames required 2", start_cycles.size() - k0);
    end else if (start_cycles[k0+1] - start_cycles[k0] != 40) begin
      failures++;
      $display("FAIL div_change_gap: got %0d cycles required 40", start_cycles[k0+1] - start_cycles[k0]);
    end
    bus_read(BASE + 32'h8, d, s);
    checks++;
    if (d !== 32'd8) begin failures++; $display("FAIL div_readback: got %0d required 8", d); end
    bus_write(BASE + 32'h8, 32'd0);
    bus_read(BASE + 32'h8, d, s);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL div_zero: got %0d required 1", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    logic        s;
    bit          ok;
    bus_write(BASE + 32'h8, 32'd4);
    exp_q.push_back('{8'hC3, 4});
    bus_write(BASE + 32'h0, 32'hC3);
    bus_write(BASE + 32'h0, 32'h99);
    repeat (17) @(posedge clk);
    #2;
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL mid_frame_bit3: got %b required 0", tx); end
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL abort_tx: got %b required 1", tx); end
    bus_read(BASE + 32'h4, d, s);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL abort_status: got %08h required 00000004", d); end
    bus_read(BASE + 32'h8, d, s);
    checks++;
    if (d !== 32'd868) begin failures++; $display("FAIL abort_div: got %0d required 868", d); end
    exp_q.push_back('{8'h3C, 868});
    bus_write(BASE + 32'h0, 32'h3C);
    wait_drain(10000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL post_reset_timeout: %0d frames outstanding required 0", exp_q.size()); end
  endtask

  task automatic test_outside_window();
    logic [31:0] outside [4];
    logic [31:0] d;
    logic        s;
    int          k0;
    bit          bad;
    outside[0] = BASE + 32'h10;
    outside[1] = BASE + 32'h18;
    outside[2] = BASE - 32'h4;
    outside[3] = 32'h2000_0004;
    k0  = start_cycles.size();
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(outside[i], d, s);
      if (d !== 32'h0 || s !== 1'b0) bad = 1'b1;
      bus_write(outside[i], 32'h0000_0008 | (i << 4));
    end
    checks++;
    if (bad) begin failures++; $display("FAIL outside_decode: sel or rd nonzero outside window, required sel=0 rd=0"); end
    repeat (50) @(posedge clk);
    #2;
    checks++;
    if (start_cycles.size() != k0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL outside_no_tx: got %0d frames busy=%b required 0 frames busy=0", start_cycles.size() - k0, busy);
    end
    bus_read(BASE + 32'h8, d, s);
    checks++;
    if (d !== 32'd868) begin failures++; $display("FAIL outside_div: got %0d required 868", d); end
    bus_read(BASE + 32'h4, d, s);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL outside_status: got %08h required 00000004", d); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_div_change();
    test_reset_mid_frame();
    test_outside_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
